// File: rtl/carry_bypass_pkg.sv
// Shared definitions for the block-serial carry-bypass subtractor:
// block width, controller states and the block-count helper.
package carry_bypass_pkg;

  localparam int BLK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int blk_count(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/bypass_sub_slice.sv
// One block of the subtract datapath: ripple full adders computing a + nb + cin,
// with a mux that forwards cin straight to cout when every bit propagates.
module bypass_sub_slice
  import carry_bypass_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] nb,
  input  logic             cin,
  output logic [BLK_W-1:0] sum,
  output logic             c7,
  output logic             cout
);

  logic [BLK_W-1:0] p;
  logic [BLK_W:0]   c;

  assign p = a ^ nb;

  // NOTE: every variable written in always_comb gets a default before the
  // loop so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLK_W; i++) begin
      c[i+1] = (a[i] & nb[i]) | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[BLK_W-1:0];
  assign c7   = c[BLK_W-1];
  // A fully propagating block cannot generate or kill, so cin passes through
  // unchanged; the mux shortens the path without changing the result.
  assign cout = (&p) ? cin : c[BLK_W];

endmodule

// File: rtl/carry_bypass_serial_subtractor.sv
// Multi-cycle a - b: one BLK_W-bit block per clock through a carry-bypass
// slice, carry held in a register between blocks, valid/ready on both sides.
module carry_bypass_serial_subtractor #(
  parameter int N     = 32,
  parameter int BLK_W = carry_bypass_pkg::BLK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow,
  output logic         zero
);

  import carry_bypass_pkg::*;

  localparam int NBLK = blk_count(N, BLK_W);
  localparam int CW   = $clog2(NBLK);

  state_t          state;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_nb;
  logic            carry;
  logic [CW-1:0]   blk;

  logic [BLK_W-1:0] slice_a;
  logic [BLK_W-1:0] slice_nb;
  logic [BLK_W-1:0] slice_sum;
  logic             slice_c7;
  logic             slice_cout;
  logic             last_blk;
  logic [N-1:0]     diff_next;

  assign slice_a  = op_a[blk*BLK_W +: BLK_W];
  assign slice_nb = op_nb[blk*BLK_W +: BLK_W];
  assign last_blk = (blk == CW'(NBLK - 1));

  bypass_sub_slice u_slice (
    .a    (slice_a),
    .nb   (slice_nb),
    .cin  (carry),
    .sum  (slice_sum),
    .c7   (slice_c7),
    .cout (slice_cout)
  );

  // The zero flag must see the block being written on the final edge too.
  always_comb begin
    diff_next = diff;
    diff_next[blk*BLK_W +: BLK_W] = slice_sum;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op_a      <= '0;
      op_nb     <= '0;
      carry     <= 1'b0;
      blk       <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_nb    <= ~b;
            carry    <= 1'b1;
            blk      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_next;
          carry <= slice_cout;
          if (last_blk) begin
            borrow    <= ~slice_cout;
            overflow  <= slice_c7 ^ slice_cout;
            zero      <= (diff_next == '0);
            blk       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            blk <= blk + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carry_bypass_serial_subtractor.sv
// Self-checking bench: a cycle-level behavioural model of the handshake and
// the arithmetic result, compared against the DUT on every falling edge.
module tb_carry_bypass_serial_subtractor;

  localparam int N  = 32;
  localparam int NB = N / 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         borrow;
  logic         overflow;
  logic         zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  carry_bypass_serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct packed {
    logic [N-1:0] d;
    logic         br;
    logic         ov;
    logic         z;
  } res_t;

  // Plain arithmetic: unsigned compare for borrow, range test of the true
  // signed difference for overflow.
  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y);
    res_t   r;
    longint sx, sy, sd;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sd   = sx - sy;
    r.d  = x - y;
    r.br = (x < y);
    r.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.z  = (r.d == '0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t m_ph = M_IDLE;
  int      m_left = 0;
  res_t    m_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ph = M_IDLE;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset in_ready", 64'(in_ready), 64'(1));
      check("reset diff", 64'(diff), 64'(0));
      check("reset flags", 64'({borrow, overflow, zero}), 64'(0));
    end else begin
      check("in_ready", 64'(in_ready), 64'(m_ph == M_IDLE));
      check("out_valid", 64'(out_valid), 64'(m_ph == M_DONE));
      if (m_ph == M_DONE) begin
        check("diff", 64'(diff), 64'(m_res.d));
        check("borrow", 64'(borrow), 64'(m_res.br));
        check("overflow", 64'(overflow), 64'(m_res.ov));
        check("zero", 64'(zero), 64'(m_res.z));
      end
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_res  = model(a, b);
          m_left = NB;
          m_ph   = M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) m_ph = M_DONE;
        end
        M_DONE: if (out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid within bound", 64'(out_valid), 64'(1));
  endtask

  // Holds the result for 'hold' cycles with random operand noise, then hands
  // it off (in_valid may be high on that edge and must not be taken).
  task automatic drain(input int hold);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("handoff out_valid", 64'(out_valid), 64'(0));
    check("handoff in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic op_lit(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] ed, input logic eb, input logic eo,
                        input logic ez, input int hold);
    int   cyc;
    res_t r;
    r = model(x, y);
    check("model pin", 64'(r), 64'({ed, eb, eo, ez}));
    start_op(x, y);
    wait_valid(cyc);
    check("latency", 64'(cyc), 64'(NB));
    check("lit diff", 64'(diff), 64'(ed));
    check("lit flags", 64'({borrow, overflow, zero}), 64'({eb, eo, ez}));
    drain(hold);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] x, y;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op_lit(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
    op_lit(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    op_lit(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
    op_lit(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 0);
    op_lit(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0);
    // Backpressure: three held cycles with operand noise on the input side.
    op_lit(32'hDEAD_BEEF, 32'h0000_BEEF, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 3);

    // Reset while the third block is being processed.
    start_op(32'hFFFF_FFFF, 32'h0000_0000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-run reset out_valid", 64'(out_valid), 64'(0));
    check("mid-run reset diff", 64'(diff), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op_lit(32'd10, 32'd20, 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b0, 0);

    // Random traffic with occasional equal or boundary operands.
    for (int n = 0; n < 60; n++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = x;
        1: x = 32'h8000_0000;
        2: y = 32'h8000_0000;
        3: begin x = {16'h0, x[15:0]}; y = {16'h0, y[15:0]}; end
        default: ;
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      out_ready = 1'b0;
      start_op(x, y);
      out_ready = 1'($urandom_range(0, 1));
      wait_valid(cyc);
      out_ready = 1'b0;
      drain($urandom_range(0, 2));
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carry_bypass_serial_subtractor.md
Name: carry_bypass_serial_subtractor

Overview:
- Multi-cycle subtractor that computes diff = a - b on N-bit two's-complement operands.
- Processes one 8-bit block per clock using a carry-bypass slice: a + ~b + 1, with the block carry registered between cycles.
- Operands enter and results leave through a valid/ready handshake.
- Sits beside the combinational adder datapath as the area-lean subtract path for the arithmetic unit.

Parameters:
- N, 32, operand width; must be a multiple of BLK_W and at least 16.
- BLK_W, 8, block width processed per cycle; fixed at 8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  N  minuend.
- b  input  N  subtrahend.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  N  a - b, modulo 2^N.
- borrow  output  1  unsigned borrow; equals ~carry-out of the final block (1 when a < b unsigned).
- overflow  output  1  signed overflow; C[N-1] XOR C[N] of the final block.
- zero  output  1  diff == 0.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - diff, borrow, overflow and zero all read 0.
  - The block counter and the carry register clear.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a into op_a and ~b into op_nb, set carry = 1, blk = 0, go to RUN.
  - in_valid without a handshake has no effect.
- RUN:
  - in_ready = 0.
  - Each cycle the slice adds op_a[blk] + op_nb[blk] + carry.
  - The result is written to diff[blk*8 +: 8], and carry takes the slice carry-out.
  - blk increments by 1 each RUN cycle.
  - When blk == N/BLK_W - 1, the same edge also:
    - latches borrow = ~slice_cout and overflow = slice_c7 ^ slice_cout;
    - sets zero from the complete diff, including the block just written;
    - moves to DONE.
- DONE:
  - out_valid = 1; diff, borrow, overflow and zero are held stable.
  - On out_ready: out_valid drops at the next edge and the FSM returns to IDLE.
  - No new operand is accepted in the same cycle as the result handshake.
- Latency: out_valid rises exactly N/BLK_W edges after the accepting edge (4 for N=32). Throughput is one operation per N/BLK_W + 2 cycles.
- Slice bypass:
  - If all 8 bits of op_a ^ op_nb are 1, the slice carry-out is the carry-in, selected through a mux; otherwise it is the ripple carry.
  - The bypass must be functionally identical to ripple.
- Result outputs are registered only; no combinational path from inputs to outputs.
- out_ready asserted while not in DONE is ignored.
- in_valid asserted while not in IDLE is ignored; captured operands are not disturbed.
- Reset mid-RUN or mid-DONE: the operation is abandoned, all outputs return to reset values immediately, and no partial result is ever presented.
- Counter width is clog2(N/BLK_W). blk never wraps past N/BLK_W - 1 within an operation.

Decomposition:
- Shared package carry_bypass_pkg holds:
  - BLK_W = 8;
  - the state enum {IDLE, RUN, DONE};
  - a function computing the block count N/BLK_W.
- One sub-module: bypass_sub_slice.
  - Inputs: 8-bit a, 8-bit nb, cin.
  - Outputs: 8-bit sum, c7 (carry into bit 7), cout.
  - Built from a ripple of full adders plus the propagate-AND bypass mux.
- Top level: FSM, operand registers, carry register, block counter, result registers.

Test Plan:
- 5 - 3 (N=32) -> after 4 cycles out_valid=1, diff=0x00000002, borrow=0, overflow=0, zero=0.
- 0x00000000 - 0x00000001 -> diff=0xFFFFFFFF, borrow=1, overflow=0, zero=0.
- 0x80000000 - 0x00000001 -> diff=0x7FFFFFFF, borrow=0, overflow=1. Also 0x7FFFFFFF - 0xFFFFFFFF -> diff=0x80000000, overflow=1, borrow=1.
- 0x12345678 - 0x12345678 (every block propagates, bypass path exercised) -> diff=0, zero=1, borrow=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands -> outputs stable, in_ready=0, new operands not captured. Assert out_ready -> IDLE next edge, in_ready=1.
- Drop rst_n during RUN (blk=2) -> out_valid=0 and diff=0 immediately. After release, a fresh 10 - 20 yields diff=0xFFFFFFF6, borrow=1.
